alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_if.sv | 42 ++++
 rtl/alu_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Bundle of the alu_seq host bus, operand beats and external-ALU signals.
//   master : host/ALU side (drives start, op, operand beats, ALU result/flags)
//   slave  : alu_seq side (drives bus_ready, operands, ALU controls, status)
// Clock and reset are kept out of the bundle and wired as plain ports.
interface alu_seq_if #(
  parameter int DATA_W = 16
);
  logic              start;
  logic [3:0]        op;
  logic [DATA_W-1:0] bus_in;
  logic              bus_valid;
  logic              bus_ready;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;
  logic [4:0]        f;
  logic              csel;
  logic              ucin;
  logic              srcin;
  logic              notALUOE;
  logic              notShiftOE;
  logic [DATA_W-1:0] alu_y;
  logic              alu_cout;
  logic              alu_zout;
  logic [DATA_W-1:0] result;
  logic              carry_flag;
  logic              zero_flag;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, op, bus_in, bus_valid, alu_y, alu_cout, alu_zout,
    input  bus_ready, a_out, b_out, f, csel, ucin, srcin, notALUOE, notShiftOE,
           result, carry_flag, zero_flag, busy, done, err
  );

  modport slave (
    input  start, op, bus_in, bus_valid, alu_y, alu_cout, alu_zout,
    output bus_ready, a_out, b_out, f, csel, ucin, srcin, notALUOE, notShiftOE,
           result, carry_flag, zero_flag, busy, done, err
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequencer for an external 16-bit ALU / shifter.
// Accepts an operation code, collects one or two operand beats from the bus,
// drives the ALU function/carry controls and output enables for a single
// execute cycle, captures result and flags, then pulses done.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous, active-high reset (priority over everything)
//   bus    : alu_seq_if.slave -- start/op request, operand beats
//            (bus_in/bus_valid/bus_ready), operand registers a_out/b_out,
//            ALU controls f/csel/ucin/srcin/notALUOE/notShiftOE, ALU inputs
//            alu_y/alu_cout/alu_zout, and result/carry_flag/zero_flag/
//            busy/done/err status.
module alu_seq #(
  parameter int DATA_W = 16
) (
  input  logic      clock,
  input  logic      reset,
  alu_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GET_A = 3'd1,
    GET_B = 3'd2,
    EXEC  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_ADC = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;

  typedef struct packed {
    logic [4:0] f;
    logic       csel;
    logic       ucin;
    logic       n_alu_oe;
    logic       n_shift_oe;
  } ctrl_t;

  // Controls held whenever the ALU is not executing: nothing enabled.
  localparam ctrl_t CTRL_IDLE = '{f: 5'b00000, csel: 1'b0, ucin: 1'b0,
                                  n_alu_oe: 1'b1, n_shift_oe: 1'b1};

  // ALU/shifter control word for an operation during its execute cycle.
  // ADC/SBC take carry-in from srcin (csel=1); SUB forces carry-in 1.
  function automatic ctrl_t exec_ctrl(input logic [3:0] op);
    ctrl_t c;
    c = '{f: 5'b00000, csel: 1'b0, ucin: 1'b0, n_alu_oe: 1'b0, n_shift_oe: 1'b1};
    case (op)
      OP_ADD:  c.f = 5'b10010;
      OP_SUB:  begin c.f = 5'b01100; c.ucin = 1'b1; end
      OP_ADC:  begin c.f = 5'b10010; c.csel = 1'b1; end
      OP_SBC:  begin c.f = 5'b01100; c.csel = 1'b1; end
      OP_AND:  c.f = 5'b10111;
      OP_OR:   c.f = 5'b11101;
      OP_XOR:  c.f = 5'b01101;
      OP_SHL:  begin c.f = 5'b00001; c.n_alu_oe = 1'b1; c.n_shift_oe = 1'b0; end
      OP_SHR:  begin c.f = 5'b00010; c.n_alu_oe = 1'b1; c.n_shift_oe = 1'b0; end
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_SHR);
  endfunction

  function automatic logic op_shift(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

  // Carry-chained ops accumulate zero across words of a multiword operation.
  function automatic logic op_chain(input logic [3:0] op);
    return (op == OP_ADC) || (op == OP_SBC);
  endfunction

  state_t            state;
  logic [3:0]        op_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [DATA_W-1:0] result_r;
  logic              carry_r;
  logic              zero_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic              ready_r;
  ctrl_t             ctrl_r;

  // All outputs are registered; each transition also sets the outputs
  // belonging to the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      op_r     <= OP_ADD;
      a_r      <= '0;
      b_r      <= '0;
      result_r <= '0;
      carry_r  <= 1'b0;
      zero_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      ready_r  <= 1'b0;
      ctrl_r   <= CTRL_IDLE;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (op_legal(bus.op)) begin
              op_r    <= bus.op;
              state   <= GET_A;
              busy_r  <= 1'b1;
              ready_r <= 1'b1;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        GET_A: begin
          if (bus.bus_valid) begin
            a_r <= bus.bus_in;
            if (op_shift(op_r)) begin
              state   <= EXEC;
              ready_r <= 1'b0;
              ctrl_r  <= exec_ctrl(op_r);
            end else begin
              state <= GET_B;
            end
          end
        end
        GET_B: begin
          if (bus.bus_valid) begin
            b_r     <= bus.bus_in;
            state   <= EXEC;
            ready_r <= 1'b0;
            ctrl_r  <= exec_ctrl(op_r);
          end
        end
        EXEC: begin
          result_r <= bus.alu_y;
          carry_r  <= bus.alu_cout;
          zero_r   <= op_chain(op_r) ? (bus.alu_zout & zero_r) : bus.alu_zout;
          ctrl_r   <= CTRL_IDLE;
          done_r   <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy_r  <= 1'b0;
          ready_r <= 1'b0;
          ctrl_r  <= CTRL_IDLE;
        end
      endcase
    end
  end

  assign bus.bus_ready  = ready_r;
  assign bus.a_out      = a_r;
  assign bus.b_out      = b_r;
  assign bus.f          = ctrl_r.f;
  assign bus.csel       = ctrl_r.csel;
  assign bus.ucin       = ctrl_r.ucin;
  assign bus.notALUOE   = ctrl_r.n_alu_oe;
  assign bus.notShiftOE = ctrl_r.n_shift_oe;
  assign bus.srcin      = carry_r;
  assign bus.result     = result_r;
  assign bus.carry_flag = carry_r;
  assign bus.zero_flag  = zero_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.err        = err_r;

endmodule
